// File: rtl/minmax_capture_pkg.sv
// Shared types for the min/max capture block: FSM state encoding and the
// scan-window helper that picks the central half of a captured record.
package minmax_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CAPT,
        SCAN
    } state_t;

    typedef struct packed {
        logic [31:0] lo;
        logic [31:0] hi;
    } window_t;

    // Window is [lo, hi): drops the first and last quarter of n samples.
    function automatic window_t scan_window(input logic [31:0] n);
        window_t w;
        w.lo = n >> 2;
        w.hi = n - (n >> 2);
        return w;
    endfunction

endpackage

// File: rtl/minmax_capture_if.sv
// Sample/control/result bundle of minmax_capture; master drives samples and
// arm/stop, slave (the capture block) returns status and results.
interface minmax_capture_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) ();

    logic [DATA_W-1:0] datain;
    logic              arm;
    logic              stop;
    logic              busy;
    logic              done;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic [DATA_W-1:0] max;
    logic [DATA_W-1:0] min;
    logic [DATA_W:0]   p2p;

    modport master (
        output datain, arm, stop,
        input  busy, done, empty, full, count, max, min, p2p
    );

    modport slave (
        input  datain, arm, stop,
        output busy, done, empty, full, count, max, min, p2p
    );

endinterface

// File: rtl/minmax_capture_sample_ram.sv
// Simple dual-port sample buffer: one write port, one synchronous read port
// with one cycle of read latency.
module sample_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/minmax_capture.sv
// Decimating capture into a circular buffer, then a scan of the central half
// of the record reporting max, min and peak-to-peak.
module minmax_capture
    import minmax_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int DIV    = 100,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    minmax_capture_if.slave  bus
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int DIV_W = $clog2(DIV);

    state_t            state;
    logic [DIV_W-1:0]  div_cnt;
    logic [ADDR_W:0]   count_r;
    logic [ADDR_W:0]   k;
    logic              done_r;
    logic              empty_r;
    logic              full_r;
    logic [DATA_W-1:0] max_r;
    logic [DATA_W-1:0] min_r;
    logic [DATA_W:0]   p2p_r;
    logic [DATA_W-1:0] run_max;
    logic [DATA_W-1:0] run_min;
    logic [DATA_W-1:0] rdata;

    logic              strobe;
    window_t           win;
    logic [31:0]       scan_len;
    logic              last_word;
    logic              scan_end;
    logic [ADDR_W-1:0] raddr;
    logic              first;
    logic [DATA_W-1:0] next_max;
    logic [DATA_W-1:0] next_min;
    logic [DATA_W:0]   next_p2p;
    logic              max_ext;
    logic              min_ext;

    function automatic logic gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        if (SIGNED != 0) begin
            return $signed(a) > $signed(b);
        end
        return a > b;
    endfunction

    assign strobe    = (state == CAPT) && (div_cnt == DIV_W'(DIV - 1));
    assign win       = scan_window(32'(count_r));
    assign scan_len  = win.hi - win.lo;
    assign last_word = (32'(k) == scan_len);
    assign scan_end  = (32'(k) == scan_len + 32'd1);
    assign raddr     = ADDR_W'(win.lo + 32'(k));

    sample_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (strobe && !bus.arm),
        .waddr (count_r[ADDR_W-1:0]),
        .wdata (bus.datain),
        .raddr (raddr),
        .rdata (rdata)
    );

    // Scan cycle k returns the word addressed in cycle k-1; k == 1 is the first.
    always_comb begin
        first    = (k == (ADDR_W+1)'(1));
        next_max = (first || gt(rdata, run_max)) ? rdata : run_max;
        next_min = (first || gt(run_min, rdata)) ? rdata : run_min;
        max_ext  = (SIGNED != 0) && next_max[DATA_W-1];
        min_ext  = (SIGNED != 0) && next_min[DATA_W-1];
        next_p2p = {max_ext, next_max} - {min_ext, next_min};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            div_cnt <= '0;
            count_r <= '0;
            k       <= '0;
            done_r  <= 1'b0;
            empty_r <= 1'b0;
            full_r  <= 1'b0;
            max_r   <= '0;
            min_r   <= '0;
            p2p_r   <= '0;
            run_max <= '0;
            run_min <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.arm) begin
                        state   <= CAPT;
                        count_r <= '0;
                        div_cnt <= '0;
                        full_r  <= 1'b0;
                        empty_r <= 1'b0;
                    end
                end
                CAPT: begin
                    k <= '0;
                    if (bus.arm) begin
                        count_r <= '0;
                        div_cnt <= '0;
                    end else begin
                        div_cnt <= strobe ? '0 : div_cnt + DIV_W'(1);
                        if (strobe) begin
                            count_r <= count_r + (ADDR_W+1)'(1);
                        end
                        if (strobe && count_r == (ADDR_W+1)'(DEPTH - 1)) begin
                            full_r <= 1'b1;
                            state  <= SCAN;
                        end else if (bus.stop) begin
                            state <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (scan_end) begin
                        state <= IDLE;
                    end else begin
                        if (k != '0) begin
                            run_max <= next_max;
                            run_min <= next_min;
                        end
                        // An empty window still pulses done but keeps old results.
                        if (last_word) begin
                            done_r <= 1'b1;
                            if (scan_len == 32'd0) begin
                                empty_r <= 1'b1;
                            end else begin
                                max_r <= next_max;
                                min_r <= next_min;
                                p2p_r <= next_p2p;
                            end
                        end
                        k <= k + (ADDR_W+1)'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy  = (state != IDLE);
    assign bus.done  = done_r;
    assign bus.empty = empty_r;
    assign bus.full  = full_r;
    assign bus.count = count_r;
    assign bus.max   = max_r;
    assign bus.min   = min_r;
    assign bus.p2p   = p2p_r;

endmodule

// File: tb/tb_minmax_capture.sv
// Bench for minmax_capture: an unsigned 16-deep instance and a signed 8-deep
// instance driven from a vector table, hand sequences and random captures.
module tb_minmax_capture;

    logic clk;
    logic rst;

    minmax_capture_if #(.DATA_W(8), .ADDR_W(4)) ifa ();
    minmax_capture_if #(.DATA_W(8), .ADDR_W(3)) ifb ();

    minmax_capture #(.DATA_W(8), .ADDR_W(4), .DIV(4), .SIGNED(0)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    minmax_capture #(.DATA_W(8), .ADDR_W(3), .DIV(3), .SIGNED(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       empty;
        logic       full;
        logic [4:0] count;
        logic [7:0] mx;
        logic [7:0] mn;
        logic [8:0] pp;
    } out_t;

    typedef struct packed {
        logic             d;
        logic [4:0]       n;
        logic             use_stop;
        logic [7:0]       mx;
        logic [7:0]       mn;
        logic [8:0]       pp;
        logic             full;
        logic             empty;
        logic [15:0][7:0] s;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] prev_mx [2];
    logic [7:0] prev_mn [2];
    logic [8:0] prev_pp [2];
    vec_t vt [6];

    function automatic int div_of(input int d);
        return (d == 0) ? 4 : 3;
    endfunction

    function automatic int depth_of(input int d);
        return (d == 0) ? 16 : 8;
    endfunction

    function automatic out_t get(input int d);
        out_t o;
        if (d == 0) begin
            o = {ifa.busy, ifa.done, ifa.empty, ifa.full, ifa.count, ifa.max, ifa.min, ifa.p2p};
        end else begin
            o = {ifb.busy, ifb.done, ifb.empty, ifb.full, 5'(ifb.count), ifb.max, ifb.min, ifb.p2p};
        end
        return o;
    endfunction

    task automatic drive(input int d, input logic a, input logic st, input logic [7:0] x);
        if (d == 0) begin
            ifa.arm = a; ifa.stop = st; ifa.datain = x;
        end else begin
            ifb.arm = a; ifb.stop = st; ifb.datain = x;
        end
    endtask

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (dut %0d): got %0h, expected %0h at %0t", nm, d, act, exp, $time);
        end
    endtask

    // Reference: extremes over the central half of the sample list.
    task automatic model(input int d, input logic [15:0][7:0] s, input int n,
                         output logic [7:0] mx, output logic [7:0] mn, output logic [8:0] pp);
        int lo, hi, v, vmax, vmin;
        lo = n / 4;
        hi = n - n / 4;
        vmax = 0;
        vmin = 0;
        for (int i = lo; i < hi; i++) begin
            v = (d == 1) ? int'($signed(s[i])) : int'(s[i]);
            if (i == lo || v > vmax) vmax = v;
            if (i == lo || v < vmin) vmin = v;
        end
        if (hi > lo) begin
            mx = 8'(vmax);
            mn = 8'(vmin);
            pp = 9'(vmax - vmin);
        end else begin
            mx = prev_mx[d];
            mn = prev_mn[d];
            pp = prev_pp[d];
        end
    endtask

    // Arm (fresh or restart) and present one sample per strobe period.
    task automatic start_feed(input int d, input logic [15:0][7:0] s, input int n);
        drive(d, 1'b1, 1'b0, s[0]);
        @(negedge clk);
        drive(d, 1'b0, 1'b0, s[0]);
        chk("count_after_arm", d, 32'(get(d).count), 32'd0);
        chk("busy_after_arm", d, 32'(get(d).busy), 32'd1);
        for (int i = 0; i < n; i++) begin
            drive(d, 1'b0, 1'b0, s[i]);
            repeat (div_of(d)) @(negedge clk);
        end
    endtask

    task automatic finish_scan(input int d, input int n, input logic [7:0] mx, input logic [7:0] mn,
                               input logic [8:0] pp, input logic full, input logic empty);
        int found;
        int len;
        out_t o;
        len = n - 2 * (n / 4);
        found = -1;
        chk("busy_scan", d, 32'(get(d).busy), 32'd1);
        for (int c = 0; c < 64; c++) begin
            if (get(d).done) begin
                found = c;
                break;
            end
            @(negedge clk);
        end
        chk("done_cycle", d, 32'(found), 32'(len + 1));
        o = get(d);
        chk("max", d, 32'(o.mx), 32'(mx));
        chk("min", d, 32'(o.mn), 32'(mn));
        chk("p2p", d, 32'(o.pp), 32'(pp));
        chk("full", d, 32'(o.full), 32'(full));
        chk("empty", d, 32'(o.empty), 32'(empty));
        chk("count_done", d, 32'(o.count), 32'(n));
        @(negedge clk);
        chk("done_pulse_end", d, 32'(get(d).done), 32'd0);
        chk("busy_after_done", d, 32'(get(d).busy), 32'd0);
        if (n > 0) begin
            prev_mx[d] = mx;
            prev_mn[d] = mn;
            prev_pp[d] = pp;
        end
    endtask

    task automatic run_vec(input int d, input logic [15:0][7:0] s, input int n, input logic use_stop,
                           input logic [7:0] mx, input logic [7:0] mn, input logic [8:0] pp,
                           input logic full, input logic empty);
        start_feed(d, s, n);
        chk("count_captured", d, 32'(get(d).count), 32'(n));
        if (use_stop) begin
            drive(d, 1'b0, 1'b1, 8'h00);
            @(negedge clk);
            drive(d, 1'b0, 1'b0, 8'h00);
        end
        finish_scan(d, n, mx, mn, pp, full, empty);
    endtask

    task automatic run_rand(input int d);
        logic [15:0][7:0] s;
        logic [7:0] mx, mn;
        logic [8:0] pp;
        int n;
        n = $urandom_range(0, depth_of(d));
        for (int i = 0; i < 16; i++) s[i] = 8'($urandom);
        model(d, s, n, mx, mn, pp);
        run_vec(d, s, n, n != depth_of(d), mx, mn, pp, n == depth_of(d), n == 0);
    endtask

    initial begin
        logic [15:0][7:0] ramp;
        logic [15:0][7:0] s1;
        out_t o;

        for (int i = 0; i < 16; i++) ramp[i] = 8'(i);

        for (int i = 0; i < 6; i++) vt[i] = '0;
        vt[0].d = 1'b0; vt[0].n = 5'd8; vt[0].use_stop = 1'b1; vt[0].s = ramp;
        vt[0].mx = 8'd5; vt[0].mn = 8'd2; vt[0].pp = 9'd3;
        vt[1].d = 1'b0; vt[1].n = 5'd0; vt[1].use_stop = 1'b1; vt[1].empty = 1'b1;
        vt[1].mx = 8'd5; vt[1].mn = 8'd2; vt[1].pp = 9'd3;
        vt[2].d = 1'b1; vt[2].n = 5'd8; vt[2].use_stop = 1'b0; vt[2].full = 1'b1;
        vt[2].s[7:0] = {8'h02, 8'h01, 8'h09, 8'h00, 8'hFD, 8'h7F, 8'h05, 8'h80};
        vt[2].mx = 8'h7F; vt[2].mn = 8'hFD; vt[2].pp = 9'd130;
        vt[3].d = 1'b1; vt[3].n = 5'd3; vt[3].use_stop = 1'b1;
        vt[3].s[2:0] = {8'h10, 8'h80, 8'h7F};
        vt[3].mx = 8'h7F; vt[3].mn = 8'h80; vt[3].pp = 9'd255;
        vt[4].d = 1'b0; vt[4].n = 5'd1; vt[4].use_stop = 1'b1; vt[4].s[0] = 8'hC8;
        vt[4].mx = 8'hC8; vt[4].mn = 8'hC8; vt[4].pp = 9'd0;
        vt[5].d = 1'b0; vt[5].n = 5'd16; vt[5].use_stop = 1'b0; vt[5].full = 1'b1;
        for (int j = 0; j < 16; j++) vt[5].s[j] = 8'h40;
        vt[5].s[4] = 8'hF0; vt[5].s[11] = 8'h01;
        vt[5].mx = 8'hF0; vt[5].mn = 8'h01; vt[5].pp = 9'h0EF;

        for (int d = 0; d < 2; d++) begin
            prev_mx[d] = '0; prev_mn[d] = '0; prev_pp[d] = '0;
            drive(d, 1'b0, 1'b0, 8'h00);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("reset_outputs", d, 32'(get(d)), 32'd0);
        end
        // Stop while idle must not start anything.
        drive(0, 1'b0, 1'b1, 8'h00);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 8'h00);
        chk("idle_stop_ignored", 0, 32'(get(0).busy), 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_vec(int'(vt[i].d), vt[i].s, int'(vt[i].n), vt[i].use_stop,
                    vt[i].mx, vt[i].mn, vt[i].pp, vt[i].full, vt[i].empty);
        end

        // Restart after three strobes: only the later samples count.
        s1 = '0;
        s1[2:0] = {8'hCC, 8'hBB, 8'hAA};
        start_feed(0, s1, 3);
        chk("count_before_restart", 0, 32'(get(0).count), 32'd3);
        s1 = '0;
        s1[3:0] = {8'd40, 8'd30, 8'd20, 8'd10};
        run_vec(0, s1, 4, 1'b1, 8'd30, 8'd20, 9'd10, 1'b0, 1'b0);

        // Reset in the middle of a scan.
        start_feed(0, ramp, 8);
        drive(0, 1'b0, 1'b1, 8'h00);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 8'h00);
        repeat (2) @(negedge clk);
        chk("busy_mid_scan", 0, 32'(get(0).busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        o = get(0);
        chk("rst_mid_scan_outputs", 0, 32'(o), 32'd0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("no_done_after_rst", 0, 32'({get(0).done, get(0).busy}), 32'd0);
        end
        for (int d = 0; d < 2; d++) begin
            prev_mx[d] = '0; prev_mn[d] = '0; prev_pp[d] = '0;
        end
        run_vec(0, ramp, 8, 1'b1, 8'd5, 8'd2, 9'd3, 1'b0, 1'b0);

        for (int r = 0; r < 16; r++) begin
            run_rand(r % 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
